// File: rtl/lamp_monitor.sv
// Safety monitor for the cyclic lamp FSM: checks encoding, order and dwell, then forwards or flashes red.
// Optional LAMP_MON_STATS_EN adds a saturating fault_count output cleared only by reset.
module lamp_monitor #(
    parameter int unsigned MIN_DWELL  = 1,
    parameter int unsigned MAX_DWELL  = 8,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [0:2] light_in,
    input  logic       clear_fault,
    output logic [0:2] lamp_out,
    output logic       fault,
    output logic [1:0] fault_code
`ifdef LAMP_MON_STATS_EN
    ,
    output logic [7:0] fault_count
`endif
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAILSAFE} state_t;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;
    localparam logic [0:2] DARK   = 3'b000;

    localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] FLASH_H = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [0:2]       cur_q, cur_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] flash_q, flash_d;
    logic [0:2]       lamp_q, lamp_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic             light_valid;
    logic [0:2]       succ;
    logic [CNT_W-1:0] dwell_inc;
    logic             enter_fail;
    logic [1:0]       fail_code;

    always_comb begin
        light_valid = (light_in == RED) || (light_in == GREEN) || (light_in == YELLOW);
        dwell_inc   = dwell_q + ONE;
        case (cur_q)
            GREEN:   succ = YELLOW;
            YELLOW:  succ = RED;
            default: succ = GREEN;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        dwell_d    = dwell_q;
        flash_d    = flash_q;
        lamp_d     = lamp_q;
        fault_d    = fault_q;
        code_d     = code_q;
        enter_fail = 1'b0;
        fail_code  = 2'd0;

        case (state_q)
            ST_INIT: begin
                if (light_valid) begin
                    cur_d   = light_in;
                    dwell_d = ONE;
                    lamp_d  = light_in;
                    state_d = ST_RUN;
                end else begin
                    // No-start timeout fires on the sample that brings the count up to MAX_DWELL
                    dwell_d = dwell_inc;
                    if (dwell_inc >= MAX_D) begin
                        enter_fail = 1'b1;
                        fail_code  = 2'd3;
                    end
                end
            end
            ST_RUN: begin
                if (!light_valid) begin
                    enter_fail = 1'b1;
                    fail_code  = 2'd1;
                end else if (light_in == cur_q) begin
                    if (dwell_q == MAX_D) begin
                        enter_fail = 1'b1;
                        fail_code  = 2'd3;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end else if (light_in != succ || dwell_q < MIN_D) begin
                    enter_fail = 1'b1;
                    fail_code  = 2'd2;
                end else begin
                    cur_d   = light_in;
                    dwell_d = ONE;
                    lamp_d  = light_in;
                end
            end
            ST_FAILSAFE: begin
                if (clear_fault) begin
                    fault_d = 1'b0;
                    code_d  = 2'd0;
                    lamp_d  = RED;
                    dwell_d = '0;
                    flash_d = '0;
                    state_d = ST_INIT;
                end else if (flash_q >= FLASH_H) begin
                    flash_d = ONE;
                    lamp_d  = (lamp_q == RED) ? DARK : RED;
                end else begin
                    flash_d = flash_q + ONE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Entry cycle counts as the first cycle of the initial red phase
        if (enter_fail) begin
            fault_d = 1'b1;
            code_d  = fail_code;
            lamp_d  = RED;
            flash_d = ONE;
            state_d = ST_FAILSAFE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cur_q   <= RED;
            dwell_q <= '0;
            flash_q <= '0;
            lamp_q  <= RED;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            flash_q <= flash_d;
            lamp_q  <= lamp_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign lamp_out   = lamp_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

`ifdef LAMP_MON_STATS_EN
    logic [7:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if (enter_fail && fcnt_q != 8'hFF) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign fault_count = fcnt_q;
`endif

endmodule

// File: tb/tb_lamp_monitor.sv
// Randomized + directed bench for lamp_monitor; two instances (MIN_DWELL 1 and 3) share stimulus.
module tb_lamp_monitor;

    localparam int MAX = 8;
    localparam int FH  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [0:2] light_in = 3'b000;
    logic       clear_fault = 1'b0;

    logic [0:2] lamp0, lamp1;
    logic       fault0, fault1;
    logic [1:0] code0, code1;
`ifdef LAMP_MON_STATS_EN
    logic [7:0] fcnt0, fcnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = default instance, 1 = MIN_DWELL 3 instance
    int m_mode[2];   // 0 init, 1 run, 2 failsafe
    int m_cur[2];
    int m_len[2];
    int m_t[2];      // cycles since failsafe entry
    int m_lamp[2];
    int m_fault[2];
    int m_code[2];
    int m_cnt[2];

    always #5 clock = ~clock;

    lamp_monitor dut0 (
        .clock(clock), .reset(reset), .light_in(light_in), .clear_fault(clear_fault),
        .lamp_out(lamp0), .fault(fault0), .fault_code(code0)
`ifdef LAMP_MON_STATS_EN
        , .fault_count(fcnt0)
`endif
    );

    lamp_monitor #(.MIN_DWELL(3), .MAX_DWELL(8), .FLASH_HALF(4), .CNT_W(8)) dut1 (
        .clock(clock), .reset(reset), .light_in(light_in), .clear_fault(clear_fault),
        .lamp_out(lamp1), .fault(fault1), .fault_code(code1)
`ifdef LAMP_MON_STATS_EN
        , .fault_count(fcnt1)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_colour(input int c);
        return (c == 1) ? 4 : (c >> 1);
    endfunction

    task automatic model_fail(input int k, input int code);
        m_mode[k]  = 2;
        m_fault[k] = 1;
        m_code[k]  = code;
        m_lamp[k]  = 4;
        m_t[k]     = 0;
        if (m_cnt[k] < 255) m_cnt[k]++;
    endtask

    task automatic model_step(input int k, input int min_d);
        int  l = int'(light_in);
        bit  v = (l == 1) || (l == 2) || (l == 4);
        if (reset) begin
            m_mode[k] = 0; m_cur[k] = 4; m_len[k] = 0; m_t[k] = 0;
            m_lamp[k] = 4; m_fault[k] = 0; m_code[k] = 0; m_cnt[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (v) begin
                m_cur[k] = l; m_len[k] = 1; m_lamp[k] = l; m_mode[k] = 1;
            end else begin
                m_len[k]++;
                if (m_len[k] >= MAX) model_fail(k, 3);
            end
        end else if (m_mode[k] == 1) begin
            if (!v) model_fail(k, 1);
            else if (l == m_cur[k]) begin
                if (m_len[k] == MAX) model_fail(k, 3);
                else m_len[k]++;
            end else if (l != next_colour(m_cur[k]) || m_len[k] < min_d) model_fail(k, 2);
            else begin
                m_cur[k] = l; m_len[k] = 1; m_lamp[k] = l;
            end
        end else begin
            if (clear_fault) begin
                m_mode[k] = 0; m_fault[k] = 0; m_code[k] = 0; m_lamp[k] = 4; m_len[k] = 0;
            end else begin
                m_t[k]++;
                m_lamp[k] = ((m_t[k] / FH) % 2 == 0) ? 4 : 0;
            end
        end
    endtask

    task automatic compare_all();
        check("d0_lamp",  int'(lamp0),  m_lamp[0]);
        check("d0_fault", int'(fault0), m_fault[0]);
        check("d0_code",  int'(code0),  m_code[0]);
        check("d1_lamp",  int'(lamp1),  m_lamp[1]);
        check("d1_fault", int'(fault1), m_fault[1]);
        check("d1_code",  int'(code1),  m_code[1]);
`ifdef LAMP_MON_STATS_EN
        check("d0_fcnt", int'(fcnt0), m_cnt[0]);
        check("d1_fcnt", int'(fcnt1), m_cnt[1]);
`endif
    endtask

    // Apply one cycle of inputs, advance the model, and compare just after the edge
    task automatic step(input logic [0:2] l, input logic c, input logic r);
        light_in    = l;
        clear_fault = c;
        reset       = r;
        model_step(0, 1);
        model_step(1, 3);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        logic [0:2] prev;
        logic [0:2] cad[3];
        int gen_c, gen_left;

        // Reset state
        step(3'b000, 1'b0, 1'b1);
        check("rst_lamp", int'(lamp0), 4);
        check("rst_fault", int'(fault0), 0);
        check("rst_code", int'(code0), 0);

        // Healthy one-cycle cadence: lamp_out lags light_in by one cycle
        cad[0] = 3'b010; cad[1] = 3'b001; cad[2] = 3'b100;
        for (int i = 0; i < 12; i++) begin
            step(cad[i % 3], 1'b0, 1'b0);
            check("cad_lag", int'(lamp0), int'(cad[i % 3]));
            check("cad_fault", int'(fault0), 0);
        end

        // Illegal encoding and flash pattern
        step(3'b110, 1'b0, 1'b0);
        check("ill_code", int'(code0), 1);
        check("ill_lamp", int'(lamp0), 4);
        for (int i = 1; i < 16; i++) begin
            step(3'($urandom_range(0, 7)), 1'b0, 1'b0);
            check("flash", int'(lamp0), ((i / 4) % 2 == 0) ? 4 : 0);
            check("ill_hold", int'(code0), 1);
        end

        // Recovery: clear wins over simultaneous violation
        step(3'b111, 1'b1, 1'b0);
        check("clr_fault", int'(fault0), 0);
        check("clr_code", int'(code0), 0);
        check("clr_lamp", int'(lamp0), 4);
        step(3'b010, 1'b0, 1'b0);
        check("clr_accept", int'(lamp0), 2);

        // Sequence error: GREEN then RED
        step(3'b100, 1'b0, 1'b0);
        check("seq_code", int'(code0), 2);

        // Early change with MIN_DWELL 3
        step(3'b000, 1'b0, 1'b1);
        step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b0);
        check("early_d1", int'(code1), 2);
        check("early_d0", int'(fault0), 0);

        // Stuck colour: ninth sample faults
        step(3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(3'b010, 1'b0, 1'b0);
        check("stuck_pre", int'(fault0), 0);
        step(3'b010, 1'b0, 1'b0);
        check("stuck_code", int'(code0), 3);

        // No-start timeout in INIT after eight invalid samples
        step(3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(3'b000, 1'b0, 1'b0);
        check("nostart_pre", int'(fault0), 0);
        step(3'b000, 1'b0, 1'b0);
        check("nostart_code", int'(code0), 3);

        // Reset mid-flash while dark
        step(3'b000, 1'b0, 1'b1);
        step(3'b010, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 1'b0);
        check("flash_dark", int'(lamp0), 0);
        step(3'b000, 1'b0, 1'b1);
        check("midrst_lamp", int'(lamp0), 4);
        check("midrst_fault", int'(fault0), 0);

        // Three fault entries, then reset
        for (int i = 0; i < 3; i++) begin
            step(3'b010, 1'b0, 1'b0);
            step(3'b111, 1'b0, 1'b0);
            step(3'b111, 1'b1, 1'b0);
        end
`ifdef LAMP_MON_STATS_EN
        check("stats_three", int'(fcnt0), 3);
`endif
        step(3'b000, 1'b0, 1'b1);
`ifdef LAMP_MON_STATS_EN
        check("stats_reset", int'(fcnt0), 0);
`endif

        // Randomized traffic: mostly legal cadence with random dwell, some glitches, clears, resets
        gen_c = 2;
        gen_left = 1;
        for (int i = 0; i < 2000; i++) begin
            logic [0:2] l;
            if ($urandom_range(0, 99) < 4) begin
                l = 3'($urandom_range(0, 7));
            end else begin
                if (gen_left == 0) begin
                    gen_c = next_colour(gen_c);
                    gen_left = $urandom_range(1, 9);
                end
                l = 3'(gen_c);
                gen_left--;
            end
            step(l, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) == 0));
        end

        prev = lamp0;
        step(prev, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lamp_monitor.md
# lamp_monitor

Downstream safety stage for the cyclic lamp FSM. Samples the FSM's 3-bit one-hot `light` code every clock and checks it for legal encoding, legal GREEN→YELLOW→RED→GREEN order, and minimum and maximum dwell time. While the code is healthy it forwards it to the physical lamp outputs. On any violation it latches a fault code and drives a flashing-red fail-safe pattern until software clears the fault.

## Interface
Parameters:
- `MIN_DWELL`, default 1: minimum consecutive cycles a colour must be present before a change is legal.
- `MAX_DWELL`, default 8: maximum consecutive cycles a colour may be present.
- `FLASH_HALF`, default 4: cycles per half-period of the fail-safe flash.
- `CNT_W`, default 8: width of the dwell and flash counters. Must hold `MAX_DWELL` and `FLASH_HALF`.

Ports:
- `clock`, in, 1: sole clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `light_in`, in, [0:2]: lamp code from the upstream FSM. Encodings: RED=100, GREEN=010, YELLOW=001.
- `clear_fault`, in, 1: level; acted on only in FAILSAFE.
- `lamp_out`, out, [0:2]: registered lamp drive, same encoding as `light_in`.
- `fault`, out, 1: registered; high while in FAILSAFE.
- `fault_code`, out, 2: registered. Values: 0 none, 1 illegal encoding, 2 illegal sequence or early change, 3 stuck or no-start timeout.

## Operation
- States: INIT, RUN, FAILSAFE.
- Internal registers:
  - `cur`: the accepted colour.
  - `dwell`: cycles `cur` has been seen, saturating at `MAX_DWELL`.
  - `flash_cnt`.
- Valid code: exactly one bit of `light_in` is set.
- Legal successor of `cur`: GREEN→YELLOW, YELLOW→RED, RED→GREEN.

INIT (entered after reset or after a fault is cleared):
- Valid `light_in`: `cur`←`light_in`, `dwell`←1, `lamp_out`←`light_in`, go to RUN.
- Invalid `light_in`: `dwell` increments. When `dwell`==`MAX_DWELL` on an invalid sample, fault with code 3.
- Invalid samples in INIT are tolerated, because the upstream FSM state is undefined until it settles.

RUN, evaluated in this priority order:
1. `light_in` invalid: fault, code 1.
2. `light_in`==`cur`:
   - If `dwell`==`MAX_DWELL`: fault, code 3.
   - Otherwise `dwell`++ and `lamp_out` holds.
3. `light_in`≠`cur` and not the legal successor: fault, code 2.
4. Legal successor with `dwell`<`MIN_DWELL`: fault, code 2.
5. Otherwise: `cur`←`light_in`, `dwell`←1, `lamp_out`←`light_in`.

Fault entry (same edge as detection):
- `fault`←1, `fault_code` latched, `lamp_out`←100, `flash_cnt`←1, go to FAILSAFE.

FAILSAFE:
- `lamp_out` toggles between 100 and 000 every `FLASH_HALF` cycles. The first RED phase includes the entry cycle.
- `light_in` is ignored. `fault_code` holds its first value; later violations do not overwrite it.
- `clear_fault`=1: `fault`←0, `fault_code`←0, `lamp_out`←100, `dwell`←0, go to INIT.

Reset (highest priority, any state, including mid-flash):
- State INIT, `lamp_out`=100, `fault`=0, `fault_code`=0, `cur`=100, `dwell`=0, `flash_cnt`=0.

## Timing
- Every output is a register; there are no combinational paths from input to output.
- `lamp_out` lags `light_in` by exactly 1 cycle in RUN.
- Fault detection latency is 1 edge: the sample that violates appears as `fault`=1 and `lamp_out`=100 after that same edge.
- `clear_fault` is honoured on the first edge it is seen high in FAILSAFE. Monitoring resumes from INIT on the following cycle.
- Simultaneous `clear_fault` and a violating `light_in` in FAILSAFE: clear wins.
- With the default `MIN_DWELL`=1, the upstream FSM's one-cycle-per-colour cadence is legal.

## Configuration
- `LAMP_MON_STATS_EN` defined:
  - Adds output `fault_count` [7:0].
  - Increments on each FAILSAFE entry and saturates at 255.
  - Cleared only by `reset`; `clear_fault` does not clear it.
- Not defined:
  - The port and its counter are absent.
  - All other behaviour is identical.

## Test plan
- Healthy cadence: reset, then `light_in` = 010, 001, 100, repeated 12 cycles → `lamp_out` equals `light_in` delayed 1 cycle, `fault`=0 throughout.
- Illegal encoding: in RUN drive 110 → after that edge `fault`=1, `fault_code`=1, `lamp_out`=100 for 4 cycles, then 000 for 4 cycles, alternating.
- Sequence error: accept 010, then drive 100 → `fault_code`=2. Separately, with `MIN_DWELL`=3, accept 010 for 2 cycles then drive 001 → `fault_code`=2.
- Stuck: hold 010 for 9 samples with `MAX_DWELL`=8 → the 9th sample faults, `fault_code`=3. Hold 000 in INIT for 8 cycles → `fault_code`=3.
- Recovery: in FAILSAFE pulse `clear_fault` alongside `light_in`=111 → next cycle `fault`=0, `fault_code`=0, `lamp_out`=100, state INIT. Then 010 is accepted.
- Reset mid-flash while `lamp_out`=000 → next cycle `lamp_out`=100, `fault`=0. With `LAMP_MON_STATS_EN`, `fault_count` counts 3 after three fault entries and reads 0 after reset.
